// File: rtl/gemm_result_checker.sv
// rtl/gemm_result_checker.sv - recomputes C = A x B with one MAC per cycle and counts mismatches against a supplied C
//
// Loads N rows of A and N rows of B^T, then for each result row r computes the
// N expected values, accepts the DUT row over the C stream and compares it
// element by element.
//
// Optional feature macro: GEMM_CHK_ERRLOG_EN (first-mismatch log outputs).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a run (sampled only while idle)
//   busy, done, pass      status: not idle / one-cycle end pulse / last run clean
//   err_count[15:0]       saturating mismatch count of the current/last run
//   a_valid/a_ready/a_data   A row beats, element k at [k*DATA_W +: DATA_W]
//   b_valid/b_ready/b_data   B^T row beats (column j of B), same packing
//   c_valid/c_ready/c_data   result row beats, element j at [j*ACC_W +: ACC_W]
//   first_err_*           (GEMM_CHK_ERRLOG_EN) first mismatch of the run

module gemm_result_checker #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int SRAM_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [SRAM_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [SRAM_WIDTH-1:0] b_data,
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [SRAM_WIDTH-1:0] c_data
`ifdef GEMM_CHK_ERRLOG_EN
  ,
  output logic                  first_err_valid,
  output logic [4:0]            first_err_row,
  output logic [4:0]            first_err_col,
  output logic [ACC_W-1:0]      first_err_got,
  output logic [ACC_W-1:0]      first_err_exp
`endif
);

  localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_WAIT_C,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // r_ld is shared: beat index while loading A/B, element index while comparing.
  logic [IDX_W-1:0] r_ld;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] r_k;
  logic [15:0]      r_err;
  logic             r_pass;

  logic signed [DATA_W-1:0] r_a  [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [DATA_W-1:0] r_bt [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [ACC_W-1:0]  r_c   [ARRAY_SIZE];
  logic signed [ACC_W-1:0]  r_exp [ARRAY_SIZE];
  logic signed [ACC_W-1:0]  r_acc;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic                       w_a_fire;
  logic                       w_b_fire;
  logic                       w_c_fire;
  logic                       w_mismatch;
  logic [15:0]                w_err_next;
  logic                       w_unused;

`ifdef GEMM_CHK_ERRLOG_EN
  logic             r_fe_valid;
  logic [4:0]       r_fe_row;
  logic [4:0]       r_fe_col;
  logic [ACC_W-1:0] r_fe_got;
  logic [ACC_W-1:0] r_fe_exp;

  assign first_err_valid = r_fe_valid;
  assign first_err_row   = r_fe_row;
  assign first_err_col   = r_fe_col;
  assign first_err_got   = r_fe_got;
  assign first_err_exp   = r_fe_exp;
`endif

  // Bits above the packed elements are don't-care.
  assign w_unused = ^{a_data, b_data, c_data};

  assign w_a_fire = a_valid & a_ready;
  assign w_b_fire = b_valid & b_ready;
  assign w_c_fire = c_valid & c_ready;

  // Signed product, sign-extended to the accumulator; the sum wraps naturally.
  assign w_prod     = (2*DATA_W)'(r_a[r_row][r_k]) * (2*DATA_W)'(r_bt[r_j][r_k]);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_acc_next = ((r_k == '0) ? '0 : r_acc) + w_prod_ext;

  assign w_mismatch = (r_c[r_ld] != r_exp[r_ld]);
  assign w_err_next = (w_mismatch && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;

  assign pass      = r_pass;
  assign err_count = r_err;

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    c_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_LOAD_A;
      end
      S_LOAD_A: begin
        a_ready = 1'b1;
        if (a_valid && (r_ld == LAST)) w_next_state = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_ready = 1'b1;
        if (b_valid && (r_ld == LAST)) w_next_state = S_COMPUTE;
      end
      S_COMPUTE: begin
        if ((r_j == LAST) && (r_k == LAST)) w_next_state = S_WAIT_C;
      end
      S_WAIT_C: begin
        c_ready = 1'b1;
        if (c_valid) w_next_state = S_COMPARE;
      end
      S_COMPARE: begin
        if (r_ld == LAST) w_next_state = (r_row == LAST) ? S_DONE : S_COMPUTE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ld    <= '0;
      r_row   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_err   <= '0;
      r_pass  <= 1'b0;
`ifdef GEMM_CHK_ERRLOG_EN
      r_fe_valid <= 1'b0;
      r_fe_row   <= '0;
      r_fe_col   <= '0;
      r_fe_got   <= '0;
      r_fe_exp   <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err  <= '0;
            r_pass <= 1'b0;
            r_ld   <= '0;
            r_row  <= '0;
            r_j    <= '0;
            r_k    <= '0;
`ifdef GEMM_CHK_ERRLOG_EN
            r_fe_valid <= 1'b0;
            r_fe_row   <= '0;
            r_fe_col   <= '0;
            r_fe_got   <= '0;
            r_fe_exp   <= '0;
`endif
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (w_a_fire || w_b_fire) r_ld <= (r_ld == LAST) ? '0 : r_ld + 1'b1;
        end
        S_COMPUTE: begin
          r_k <= (r_k == LAST) ? '0 : r_k + 1'b1;
          if (r_k == LAST) r_j <= (r_j == LAST) ? '0 : r_j + 1'b1;
        end
        S_COMPARE: begin
          r_err <= w_err_next;
          r_ld  <= (r_ld == LAST) ? '0 : r_ld + 1'b1;
`ifdef GEMM_CHK_ERRLOG_EN
          if (w_mismatch && !r_fe_valid) begin
            r_fe_valid <= 1'b1;
            r_fe_row   <= 5'(r_row);
            r_fe_col   <= 5'(r_ld);
            r_fe_got   <= r_c[r_ld];
            r_fe_exp   <= r_exp[r_ld];
          end
`endif
          if (r_ld == LAST) begin
            // pass is made valid in the same cycle done pulses
            if (r_row == LAST) r_pass <= (w_err_next == 16'd0);
            else               r_row  <= r_row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data buffers and the accumulator carry no reset; they are always written
  // before being read within a run.
  always_ff @(posedge clk) begin
    if (w_a_fire) begin
      for (int k = 0; k < ARRAY_SIZE; k++) r_a[r_ld][k] <= a_data[k*DATA_W +: DATA_W];
    end
    if (w_b_fire) begin
      for (int k = 0; k < ARRAY_SIZE; k++) r_bt[r_ld][k] <= b_data[k*DATA_W +: DATA_W];
    end
    if (w_c_fire) begin
      for (int k = 0; k < ARRAY_SIZE; k++) r_c[k] <= c_data[k*ACC_W +: ACC_W];
    end
    if (r_state == S_COMPUTE) begin
      r_acc <= w_acc_next;
      if (r_k == LAST) r_exp[r_j] <= w_acc_next;
    end
  end

endmodule

// File: tb/tb_gemm_result_checker.sv
// tb/tb_gemm_result_checker.sv - directed and randomized checks of gemm_result_checker at N=4 and N=16

module tb_gemm_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic         sel;
  logic         a_valid, b_valid, c_valid;
  logic [511:0] a_data, b_data, c_data;

  logic         busy4, done4, pass4, ar4, br4, cr4;
  logic [15:0]  err4;
  logic         busy16, done16, pass16, ar16, br16, cr16;
  logic [15:0]  err16;

  logic         m_busy, m_done, m_pass, m_ar, m_br, m_cr;
  logic [15:0]  m_err;

  int checks = 0;
  int errors = 0;

  int A  [16][16];
  int BT [16][16];
  int C  [16][16];

`ifdef GEMM_CHK_ERRLOG_EN
  logic        fev4, fev16;
  logic [4:0]  fer4, fec4, fer16, fec16;
  logic [31:0] feg4, fee4, feg16, fee16;
  logic        m_fev;
  logic [4:0]  m_fer, m_fec;
  logic [31:0] m_feg, m_fee;
  assign m_fev = sel ? fev16 : fev4;
  assign m_fer = sel ? fer16 : fer4;
  assign m_fec = sel ? fec16 : fec4;
  assign m_feg = sel ? feg16 : feg4;
  assign m_fee = sel ? fee16 : fee4;
`endif

  gemm_result_checker #(.ARRAY_SIZE(4), .DATA_W(8), .ACC_W(32), .SRAM_WIDTH(256)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & ~sel),
    .busy      (busy4),
    .done      (done4),
    .pass      (pass4),
    .err_count (err4),
    .a_valid   (a_valid & ~sel),
    .a_ready   (ar4),
    .a_data    (a_data[255:0]),
    .b_valid   (b_valid & ~sel),
    .b_ready   (br4),
    .b_data    (b_data[255:0]),
    .c_valid   (c_valid & ~sel),
    .c_ready   (cr4),
    .c_data    (c_data[255:0])
`ifdef GEMM_CHK_ERRLOG_EN
    ,
    .first_err_valid (fev4),
    .first_err_row   (fer4),
    .first_err_col   (fec4),
    .first_err_got   (feg4),
    .first_err_exp   (fee4)
`endif
  );

  gemm_result_checker #(.ARRAY_SIZE(16), .DATA_W(8), .ACC_W(32), .SRAM_WIDTH(512)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & sel),
    .busy      (busy16),
    .done      (done16),
    .pass      (pass16),
    .err_count (err16),
    .a_valid   (a_valid & sel),
    .a_ready   (ar16),
    .a_data    (a_data),
    .b_valid   (b_valid & sel),
    .b_ready   (br16),
    .b_data    (b_data),
    .c_valid   (c_valid & sel),
    .c_ready   (cr16),
    .c_data    (c_data)
`ifdef GEMM_CHK_ERRLOG_EN
    ,
    .first_err_valid (fev16),
    .first_err_row   (fer16),
    .first_err_col   (fec16),
    .first_err_got   (feg16),
    .first_err_exp   (fee16)
`endif
  );

  assign m_busy = sel ? busy16 : busy4;
  assign m_done = sel ? done16 : done4;
  assign m_pass = sel ? pass16 : pass4;
  assign m_err  = sel ? err16  : err4;
  assign m_ar   = sel ? ar16   : ar4;
  assign m_br   = sel ? br16   : br4;
  assign m_cr   = sel ? cr16   : cr4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: C[r][j] = sum_k A[r][k] * B^T[j][k], 32-bit wrap.
  function automatic int ref_c(int n, int r, int j);
    int s = 0;
    for (int k = 0; k < n; k++) s += A[r][k] * BT[j][k];
    return s;
  endfunction

  function automatic logic [511:0] rnd_bus();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic fill_ref(input int n);
    for (int r = 0; r < n; r++)
      for (int j = 0; j < n; j++) C[r][j] = ref_c(n, r, j);
  endtask

  task automatic load_spec();
    int a_t [4][4] = '{'{51, -15, 6, -99}, '{-65, 89, -53, 45}, '{31, -82, 19, 127}, '{-38, -77, 100, -12}};
    int b_t [4][4] = '{'{-23, 94, -66, 17}, '{67, -31, 48, -95}, '{-55, 7, 102, 33}, '{82, -44, -89, 61}};
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        A[r][k]  = a_t[r][k];
        BT[r][k] = b_t[r][k];
      end
    fill_ref(4);
  endtask

  task automatic run_check(input int n, input bit gaps, input bit spur, output int cycles);
    int ia = 0, ib = 0, ic = 0, cyc;
    bit fin = 0, txa, txb, txc;
    @(negedge clk);
    start = 1'b1;
    cyc = 1;
    @(negedge clk);
    while (!fin && cyc < 20000) begin
      cyc++;
      if (m_done) begin
        fin = 1;
      end else begin
        start   = spur ? ($urandom_range(0, 2) == 0) : 1'b0;
        a_valid = (ia < n);
        b_valid = (ib < n);
        c_valid = (ic < n) && !(gaps && ($urandom_range(0, 2) == 0));
        a_data = rnd_bus();
        b_data = rnd_bus();
        c_data = rnd_bus();
        for (int k = 0; k < n; k++) begin
          if (ia < n) a_data[k*8 +: 8] = 8'(A[ia][k]);
          if (ib < n) b_data[k*8 +: 8] = 8'(BT[ib][k]);
          if (ic < n) c_data[k*32 +: 32] = C[ic][k];
        end
        txa = a_valid && m_ar;
        txb = b_valid && m_br;
        txc = c_valid && m_cr;
        @(negedge clk);
        if (txa) ia++;
        if (txb) ib++;
        if (txc) ic++;
      end
    end
    start   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    c_valid = 1'b0;
    check("run_reached_done", 32'(fin), 32'd1);
    cycles = cyc;
  endtask

  // Runs once and compares against the model; cycle count checked only for stall-free runs.
  task automatic run_and_check(input string tag, input int n, input bit gaps, input bit spur);
    int cycles, exp_err = 0, fr = -1, fc = 0, fg = 0, fx = 0;
    for (int r = 0; r < n; r++)
      for (int j = 0; j < n; j++)
        if (C[r][j] != ref_c(n, r, j)) begin
          if (fr < 0) begin
            fr = r; fc = j; fg = C[r][j]; fx = ref_c(n, r, j);
          end
          exp_err++;
        end
    run_check(n, gaps, spur, cycles);
    check({tag, "_err_count"}, 32'(m_err), 32'(exp_err));
    check({tag, "_pass"}, 32'(m_pass), 32'(exp_err == 0));
    if (!gaps) check({tag, "_cycles"}, 32'(cycles), 32'(2*n + n*(n*n + 1 + n) + 2));
`ifdef GEMM_CHK_ERRLOG_EN
    check({tag, "_fe_valid"}, 32'(m_fev), 32'(fr >= 0));
    if (fr >= 0) begin
      check({tag, "_fe_row"}, 32'(m_fer), 32'(fr));
      check({tag, "_fe_col"}, 32'(m_fec), 32'(fc));
      check({tag, "_fe_got"}, m_feg, fg);
      check({tag, "_fe_exp"}, m_fee, fx);
    end
`endif
    repeat (3) @(negedge clk);
    check({tag, "_done_low_after"}, 32'(m_done), 32'd0);
    check({tag, "_idle_after"}, 32'(m_busy), 32'd0);
    check({tag, "_pass_held"}, 32'(m_pass), 32'(exp_err == 0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_busy", 32'(m_busy), 32'd0);
      check("rst_done", 32'(m_done), 32'd0);
      check("rst_pass", 32'(m_pass), 32'd0);
      check("rst_err", 32'(m_err), 32'd0);
      check("rst_a_ready", 32'(m_ar), 32'd0);
      check("rst_b_ready", 32'(m_br), 32'd0);
      check("rst_c_ready", 32'(m_cr), 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    load_spec();
    run_and_check("n4_golden", 4, 0, 0);

    C[1][1] = -13932;
    run_and_check("n4_one_err", 4, 0, 0);
    check("n4_one_err_model_exp", 32'(ref_c(4, 1, 1)), -32'sd13933);

    fill_ref(4);
    run_and_check("n4_gaps_spur", 4, 1, 1);

    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          A[r][k]  = int'($urandom_range(0, 255)) - 128;
          BT[r][k] = int'($urandom_range(0, 255)) - 128;
        end
      fill_ref(4);
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          if ($urandom_range(0, 4) == 0) C[r][j] += int'($urandom_range(1, 1000));
      run_and_check("n4_random", 4, t[0], t[1]);
    end

    // Reset in LOAD_B aborts the run.
    load_spec();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_data  = '0;
      for (int k = 0; k < 4; k++) a_data[k*8 +: 8] = 8'(A[i][k]);
      @(negedge clk);
    end
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_data  = '0;
    for (int k = 0; k < 4; k++) b_data[k*8 +: 8] = 8'(BT[0][k]);
    check("midrun_b_ready", 32'(m_br), 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check("midrun_rst_busy", 32'(m_busy), 32'd0);
    check("midrun_rst_b_ready", 32'(m_br), 32'd0);
    check("midrun_rst_err", 32'(m_err), 32'd0);
    rst_n = 1'b1;
    run_and_check("n4_after_reset", 4, 0, 0);

    sel = 1'b1;
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) begin
        A[r][k]  = -128;
        BT[r][k] = -128;
      end
    fill_ref(16);
    check("n16_model_value", 32'(C[5][7]), 32'd262144);
    run_and_check("n16_golden", 16, 0, 0);
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 16; j++) C[r][j] = 0;
    run_and_check("n16_all_zero", 16, 0, 0);
    check("n16_all_zero_count", 32'(m_err), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
